// File: rtl/linebuf_window_ctrl.sv
// Sequencer for the two cascaded single-line buffers feeding a 3x3 Sobel window:
// raster counters, buffer write/clear control, window-valid and fill-flag checking.
module linebuf_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int COL_W = 10,
  parameter int ROW_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start_i,
  input  logic             pix_valid_i,
  output logic             ready_o,
  output logic             lb0_we_o,
  output logic             lb1_we_o,
  output logic             lb_rst_o,
  input  logic             lb0_done_i,
  input  logic             lb1_done_i,
  output logic             win_valid_o,
  output logic [COL_W-1:0] ctr_col_o,
  output logic [ROW_W-1:0] ctr_row_o,
  output logic             frame_done_o,
  output logic             err_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_FILL   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  state_t           state, state_nxt;
  logic [COL_W-1:0] in_col;
  logic [ROW_W-1:0] in_row;
  logic             accept;
  logic             col_last;
  logic             last_pix;
  logic             fill_bad;

  assign accept   = pix_valid_i & ready_o;
  assign col_last = (in_col == COL_LAST);
  assign last_pix = accept & col_last & (in_row == ROW_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // frame_start_i wins over any accept, including the last pixel
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (frame_start_i) state_nxt = S_CLR;
      S_CLR:    state_nxt = S_FILL;
      S_FILL: begin
        if (frame_start_i)                            state_nxt = S_CLR;
        else if (accept && col_last && in_row == ROW_ONE) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (frame_start_i) state_nxt = S_CLR;
        else if (last_pix) state_nxt = S_DONE;
      end
      S_DONE:   state_nxt = frame_start_i ? S_CLR : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o      = ((state == S_FILL) || (state == S_STREAM)) && !frame_start_i;
    frame_done_o = (state == S_DONE);
    state_o      = state;
    lb0_we_o     = accept;
    lb1_we_o     = accept & lb0_done_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lb_rst_o <= 1'b1;
    else     lb_rst_o <= (state_nxt == S_CLR);
  end

  // Row saturates on the final pixel; only CLR rewinds the raster position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_col <= '0;
      in_row <= '0;
    end else if (state == S_CLR) begin
      in_col <= '0;
      in_row <= '0;
    end else if (accept) begin
      if (col_last) begin
        in_col <= '0;
        if (in_row != ROW_LAST) in_row <= in_row + ROW_ONE;
      end else begin
        in_col <= in_col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid_o <= 1'b0;
      ctr_col_o   <= '0;
      ctr_row_o   <= '0;
    end else begin
      win_valid_o <= accept && (in_row >= ROW_TWO) && (in_col >= COL_TWO);
      if (accept && (in_row >= ROW_TWO) && (in_col >= COL_TWO)) begin
        ctr_col_o <= in_col - COL_W'(1);
        ctr_row_o <= in_row - ROW_ONE;
      end
    end
  end

  // n >= IMG_W is row >= 1, n >= 2*IMG_W is row >= 2
  assign fill_bad = (lb0_done_i != (in_row != '0)) || (lb1_done_i != (in_row >= ROW_TWO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    err_o <= 1'b0;
    else if (state == S_CLR)    err_o <= 1'b0;
    else if (accept && fill_bad) err_o <= 1'b1;
  end

endmodule

// File: tb/tb_linebuf_window_ctrl.sv
// Bench for linebuf_window_ctrl on a 5x4 image with behavioural line-buffer models.
module tb_linebuf_window_ctrl;
  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst, fs, pv;
  logic       ready, we0, we1, lbrst, lb0_done, lb1_done, wv, fdone, err;
  logic [2:0] ccol;
  logic [1:0] crow;
  logic [2:0] st;

  linebuf_window_ctrl #(.IMG_W(W), .IMG_H(H), .COL_W(3), .ROW_W(2)) dut (
    .clk(clk), .rst(rst), .frame_start_i(fs), .pix_valid_i(pv), .ready_o(ready),
    .lb0_we_o(we0), .lb1_we_o(we1), .lb_rst_o(lbrst), .lb0_done_i(lb0_done),
    .lb1_done_i(lb1_done), .win_valid_o(wv), .ctr_col_o(ccol), .ctr_row_o(crow),
    .frame_done_o(fdone), .err_o(err), .state_o(st));

  always #5 clk = ~clk;

  // line buffer models: full once DEPTH pixels written since last clear
  int  cnt0, cnt1;
  bit  force_zero;
  bit  rnd_force_en;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= 0; cnt1 <= 0;
    end else if (lbrst) begin
      cnt0 <= 0; cnt1 <= 0;
    end else begin
      if (we0 && cnt0 < W) cnt0 <= cnt0 + 1;
      if (we1 && cnt1 < W) cnt1 <= cnt1 + 1;
    end
  end
  assign lb0_done = (cnt0 == W) && !force_zero;
  assign lb1_done = (cnt1 == W);

  int nvec = 0, nbad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // reference model: frame phase plus number of pixels accepted in this frame
  localparam int M_IDLE = 0, M_CLEAR = 1, M_RUN = 2, M_END = 3;
  int ph, m_k, m_cc, m_cr;
  bit m_lbrst, m_wv, m_err;
  int got_win[$];
  bit seen_done;
  int first_we1;
  int force_at = -1;

  task automatic model_reset();
    ph = M_IDLE; m_k = 0; m_cc = 0; m_cr = 0;
    m_lbrst = 1'b1; m_wv = 1'b0; m_err = 1'b0;
  endtask

  function automatic int exp_state();
    case (ph)
      M_IDLE:  return 0;
      M_CLEAR: return 1;
      M_RUN:   return (m_k < 2 * W) ? 2 : 3;
      default: return 4;
    endcase
  endfunction

  task automatic cycle(input bit f, input bit p);
    bit exp_ready, acc, nwv, last;
    logic [14:0] act_v, exp_v;
    int r, c;
    fs = f; pv = p;
    force_zero = (force_at >= 0 && ph == M_RUN && m_k == force_at) ||
                 (rnd_force_en && $urandom_range(0, 63) == 0);
    @(negedge clk);
    exp_ready = (ph == M_RUN) && !f;
    acc = p && exp_ready;
    exp_v = {3'(exp_state()), exp_ready, acc, acc && lb0_done, m_lbrst, m_wv,
             ph == M_END, m_err, 3'(m_cc), 2'(m_cr)};
    act_v = {st, ready, we0, we1, lbrst, wv, fdone, err, ccol, crow};
    chk("cycle_outputs", int'(act_v), int'(exp_v));
    if (wv) got_win.push_back(int'(crow) * 16 + int'(ccol));
    if (fdone) seen_done = 1'b1;
    if (we1 && first_we1 < 0) first_we1 = m_k;
    nwv = 1'b0; last = 1'b0;
    if (acc) begin
      r = m_k / W; c = m_k % W;
      nwv = (r >= 2) && (c >= 2);
      if (nwv) begin m_cc = c - 1; m_cr = r - 1; end
      if ((lb0_done != (m_k >= W)) || (lb1_done != (m_k >= 2 * W))) m_err = 1'b1;
      last = (m_k == W * H - 1);
      m_k++;
    end
    case (ph)
      M_IDLE:  if (f) ph = M_CLEAR;
      M_CLEAR: begin ph = M_RUN; m_k = 0; m_err = 1'b0; end
      M_RUN:   if (f) ph = M_CLEAR; else if (last) ph = M_END;
      default: ph = f ? M_CLEAR : M_IDLE;
    endcase
    m_lbrst = (ph == M_CLEAR);
    m_wv = nwv;
    @(posedge clk); #1;
  endtask

  // start a frame and feed it; pixels offered every 'period' cycles
  task automatic run_frame(input int period, input int abort_at);
    int ab;
    ab = abort_at;
    seen_done = 1'b0;
    first_we1 = -1;
    got_win.delete();
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 400 && !seen_done; i++) begin
      if (ab >= 0 && ph == M_RUN && m_k == ab) begin
        cycle(1'b1, 1'b1);
        ab = -1;
      end else begin
        cycle(1'b0, (i % period) == 0);
      end
    end
    chk("frame_done_seen", int'(seen_done), 1);
  endtask

  task automatic check_windows(input string nm);
    int idx;
    idx = 0;
    chk({nm, "_count"}, got_win.size(), (H - 2) * (W - 2));
    for (int r = 1; r <= H - 2; r++)
      for (int c = 1; c <= W - 2; c++) begin
        if (idx < got_win.size()) chk({nm, "_centre"}, got_win[idx], r * 16 + c);
        idx++;
      end
  endtask

  typedef struct {
    bit f, p;
    int exp_st;
    bit exp_ready, exp_we0, exp_lbrst;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{0, 1, 0, 0, 0, 1};
    tbl[1] = '{0, 1, 0, 0, 0, 0};
    tbl[2] = '{1, 1, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 1, 0, 0, 1};
    tbl[4] = '{0, 1, 2, 1, 1, 0};
    tbl[5] = '{0, 0, 2, 1, 0, 0};
    tbl[6] = '{1, 1, 2, 0, 0, 0};
    tbl[7] = '{0, 0, 1, 0, 0, 1};
    tbl[8] = '{0, 0, 2, 1, 0, 0};

    rst = 1'b1; fs = 1'b0; pv = 1'b0; force_zero = 1'b0; rnd_force_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // IDLE/CLR ignore pixels, abort from FILL
    for (int i = 0; i < 9; i++) begin
      fs = tbl[i].f; pv = tbl[i].p;
      #1;
      chk("tbl_state", int'(st), tbl[i].exp_st);
      chk("tbl_ready", int'(ready), int'(tbl[i].exp_ready));
      chk("tbl_we0", int'(we0), int'(tbl[i].exp_we0));
      chk("tbl_lbrst", int'(lbrst), int'(tbl[i].exp_lbrst));
      cycle(tbl[i].f, tbl[i].p);
    end

    run_frame(1, -1);
    check_windows("back2back");
    chk("back2back_first_we1", first_we1, W);
    chk("back2back_err", int'(err), 0);

    run_frame(3, -1);
    check_windows("sparse");
    chk("sparse_first_we1", first_we1, W);

    run_frame(1, 8);
    check_windows("abort_restart");

    force_at = 6;
    run_frame(1, -1);
    force_at = -1;
    chk("forced_err_held", int'(err), 1);
    cycle(1'b0, 1'b1);
    chk("forced_err_idle", int'(err), 1);
    run_frame(1, -1);
    chk("err_cleared", int'(err), 0);

    // asynchronous reset in the middle of STREAM
    seen_done = 1'b0;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 13; i++) cycle(1'b0, 1'b1);
    pv = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_vec", int'({st, ready, we0, we1, lbrst, wv, fdone, err, ccol, crow}),
        int'({3'd0, 4'b0001, 3'b000, 3'd0, 2'd0}));
    #1 rst = 1'b0;
    model_reset();
    cycle(1'b0, 1'b0);
    run_frame(1, -1);
    check_windows("after_rst");

    rnd_force_en = 1'b1;
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0);
    rnd_force_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
